serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_sub.sv | 19 +
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding
//   and the default operand width.
package serial_sub_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// full_sub
//   Combinational 1-bit full subtractor computing A - B - Bin.
//   Ports:
//     A, B, Bin : minuend bit, subtrahend bit, borrow-in
//     D         : difference bit
//     Bout      : borrow-out
module full_sub (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  // Borrow when A=0,B=1, or when A==B and a borrow is already pending.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial N-bit subtractor: D = A - B - Bin, one bit per clock, LSB
//   first, with a registered borrow chain through a single full_sub cell.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     Start      : launch request, honoured only in IDLE
//     A, B, Bin  : operands, captured when Start is accepted
//     D, Bout    : registered result; held until the next completion
//     Busy       : high while an operation is in RUN or DONE
//     Done       : one-cycle pulse in the cycle D/Bout update
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         Busy,
  output logic         Done
);

  state_t        state_reg;
  logic [N-1:0]  sa_reg;
  logic [N-1:0]  sb_reg;
  logic [N-1:0]  res_reg;
  logic          br_reg;
  logic [CW-1:0] cnt_reg;

  logic          cell_d;
  logic          cell_bout;
  logic [N-1:0]  res_next;
  logic          last_bit;

  // Operand LSBs always hold the bit being processed, since sa/sb shift right.
  full_sub u_cell (
    .A    (sa_reg[0]),
    .B    (sb_reg[0]),
    .Bin  (br_reg),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  // New difference bit enters at the MSB; after N shifts bit 0 is the LSB.
  assign res_next = {cell_d, res_reg[N-1:1]};
  assign last_bit = (cnt_reg == CW'(N - 1));
  assign Busy     = (state_reg == S_RUN) || (state_reg == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      D         <= '0;
      Bout      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            sa_reg    <= A;
            sb_reg    <= B;
            br_reg    <= Bin;
            cnt_reg   <= '0;
            res_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          br_reg  <= cell_bout;
          res_reg <= res_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_bit) begin
            D         <= res_next;
            Bout      <= cell_bout;
            Done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          Done      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          Done      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub
//   Directed self-checking bench for serial_sub (N=8) plus an exhaustive
//   sweep of the full_sub cell. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
module tb_serial_sub;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         Start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic [N-1:0] D;
  logic         Bout;
  logic         Busy;
  logic         Done;

  logic fs_a, fs_b, fs_bin, fs_d, fs_bout;

  int checks = 0;
  int errors = 0;

  serial_sub #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .Busy  (Busy),
    .Done  (Done)
  );

  full_sub u_fs (
    .A    (fs_a),
    .B    (fs_b),
    .Bin  (fs_bin),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands at a falling edge; the following rising edge accepts them.
  // Operands are scrambled afterwards to show they are not re-sampled.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    Start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bin;
    step();
    Start = 1'b0;
    A     = 8'hA5;
    B     = 8'h5A;
    Bin   = 1'b1;
  endtask

  // Counts rising edges until Done is seen, bounded so a dead DUT cannot hang.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      edges++;
      if (Done) return;
    end
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin, input logic [N-1:0] exp_d, input logic exp_bout);
    int edges;
    start_op(a, b, bin);
    wait_done(edges);
    check({tag, "_latency"}, edges + 1, N + 1);
    check({tag, "_d"}, D, exp_d);
    check({tag, "_bout"}, Bout, exp_bout);
    check({tag, "_busy_in_done"}, Busy, 1);
    step();
    check({tag, "_done_low"}, Done, 0);
    check({tag, "_busy_low"}, Busy, 0);
    check({tag, "_d_hold"}, D, exp_d);
    $display("op %s: A=%0h B=%0h Bin=%0b -> D=%0h Bout=%0b latency=%0d",
             tag, a, b, bin, D, Bout, edges + 1);
  endtask

  initial begin
    int edges;
    int done_count;
    int busy_count;
    logic [7:0] fs_d_tab;
    logic [7:0] fs_b_tab;

    rst   = 1'b1;
    Start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    fs_a  = 1'b0;
    fs_b  = 1'b0;
    fs_bin = 1'b0;

    // Full subtractor truth table indexed by {A,B,Bin}.
    fs_d_tab = 8'b1001_0110;
    fs_b_tab = 8'b1000_1110;
    for (int v = 0; v < 8; v++) begin
      {fs_a, fs_b, fs_bin} = 3'(v);
      #1;
      check($sformatf("fs_d_%0d", v), fs_d, fs_d_tab[v]);
      check($sformatf("fs_bout_%0d", v), fs_bout, fs_b_tab[v]);
      $display("full_sub: A=%0b B=%0b Bin=%0b -> D=%0b Bout=%0b", fs_a, fs_b, fs_bin, fs_d, fs_bout);
    end

    step();
    step();
    rst = 1'b0;
    check("rst_d", D, 0);
    check("rst_bout", Bout, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);

    run_op("5m3", 8'd5, 8'd3, 1'b0, 8'h02, 1'b0);

    // D must hold the old result while the next operation is running.
    start_op(8'd3, 8'd5, 1'b0);
    step();
    step();
    check("hold_mid_run_d", D, 8'h02);
    check("hold_mid_run_busy", Busy, 1);
    wait_done(edges);
    check("3m5_latency", edges + 3, N + 1);
    check("3m5_d", D, 8'hFE);
    check("3m5_bout", Bout, 1);
    step();
    $display("op 3m5: D=%0h Bout=%0b", D, Bout);

    // Back-to-back: run_op leaves us where the next Start hits the earliest legal edge.
    run_op("0m0b1", 8'd0, 8'd0, 1'b1, 8'hFF, 1'b1);
    run_op("FFmFF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // Start re-pulsed during RUN must be ignored.
    start_op(8'd7, 8'd2, 1'b0);
    step();
    step();
    step();
    Start = 1'b1;
    A     = 8'd9;
    B     = 8'd1;
    step();
    Start = 1'b0;
    wait_done(edges);
    check("repulse_latency", edges + 5, N + 1);
    check("repulse_d", D, 8'h05);
    check("repulse_bout", Bout, 0);
    done_count = 0;
    busy_count = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Done) done_count++;
      if (Busy) busy_count++;
    end
    check("repulse_extra_done", done_count, 0);
    check("repulse_extra_busy", busy_count, 0);
    check("repulse_d_hold", D, 8'h05);
    $display("op repulse: D=%0h Bout=%0b", D, Bout);

    // Reset at edge k+4 aborts the operation and clears the result.
    start_op(8'd100, 8'd1, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_d", D, 0);
    check("abort_bout", Bout, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Done) done_count++;
    end
    check("abort_no_done", done_count, 0);
    $display("op abort: D=%0h Bout=%0b Busy=%0b", D, Bout, Busy);

    run_op("100m1", 8'd100, 8'd1, 1'b0, 8'h63, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
